pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives PC enable and
//  per-latch stall/flush for IF/ID, ID/EX, EX/MEM, MEM/WB from fetch/data hit,

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/hazard_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline control types
package cpu_types_pkg;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } hz_state_t;
endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use comparator between EX load and ID sources
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_regwrite,
  input  logic             ex_dREN,
  output logic             load_use
);
  logic rs_match;
  logic rt_match;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs_match = (ex_wsel == id_rs);
  assign rt_match = id_uses_rt && (ex_wsel == id_rt);
  assign load_use = ex_dREN && ex_regwrite && (ex_wsel != '0) && (rs_match || rt_match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer and perf counters for the 5-stage pipeline
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = cpu_types_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_regwrite,
  input  logic             ex_dREN,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  hz_state_t state, next_state;
  logic      redirect_pend, pend_nxt;
  logic      load_use;
  logic      dmiss;
  logic      flush_inc;
  logic      stall_inc;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_wsel     (ex_wsel),
    .ex_regwrite (ex_regwrite),
    .ex_dREN     (ex_dREN),
    .load_use    (load_use)
  );

  assign dmiss = (mem_dREN || mem_dWEN) && !dhit;

  always_comb begin
    pc_en        = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    flush_inc    = 1'b0;
    next_state   = state;
    pend_nxt     = redirect_pend;
    if (state == HALT) begin
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
    end else if (wb_halt) begin
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
      next_state   = HALT;
    end else if (dmiss) begin
      // the stalled MEM op must not retire twice, so WB gets a bubble
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
      next_state   = MEMWAIT;
    end else begin
      next_state = RUN;
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pc_en       = ihit;
        flush_inc   = 1'b1;
        pend_nxt    = redirect_pend || !ihit;
      end else if (redirect_pend && ihit) begin
        // the fetch that was in flight at redirect time is wrong-path
        if_id_flush = 1'b1;
        pc_en       = 1'b1;
        pend_nxt    = 1'b0;
      end else if (load_use) begin
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!ihit) begin
        if_id_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  assign stall_inc = (state != HALT) && !pc_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= RUN;
      redirect_pend <= 1'b0;
      halted        <= 1'b0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
    end else begin
      state         <= next_state;
      redirect_pend <= pend_nxt;
      halted        <= (next_state == HALT);
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, id_uses_rt, ex_regwrite, ex_dREN;
  logic       mem_dREN, mem_dWEN, ex_redirect, wb_halt;
  logic [4:0] id_rs, id_rt, ex_wsel;

  logic        pc_en, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_if_id_stall, s_id_ex_stall, s_ex_mem_stall, s_mem_wb_stall;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_halted;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;
  int es = 0;
  int ef = 0;

  // {pc_en, stalls if/id..mem/wb, flushes if/id..mem/wb, halted}
  localparam logic [9:0] ADV     = 10'b1_0000_0000_0;
  localparam logic [9:0] LU      = 10'b0_1000_0100_0;
  localparam logic [9:0] MISS    = 10'b0_1110_0001_0;
  localparam logic [9:0] HALTING = 10'b0_1111_0000_0;
  localparam logic [9:0] HALTED  = 10'b0_1111_0000_1;
  localparam logic [9:0] RD_HIT  = 10'b1_0000_1100_0;
  localparam logic [9:0] RD_MISS = 10'b0_0000_1100_0;
  localparam logic [9:0] NOFETCH = 10'b0_0000_1000_0;
  localparam logic [9:0] DISCARD = 10'b1_0000_1000_0;

  wire [9:0] outs = {pc_en, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted};

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_wsel(ex_wsel), .ex_regwrite(ex_regwrite), .ex_dREN(ex_dREN),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(3)) dut_s (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_wsel(ex_wsel), .ex_regwrite(ex_regwrite), .ex_dREN(ex_dREN),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
    .pc_en(s_pc_en), .if_id_stall(s_if_id_stall), .id_ex_stall(s_id_ex_stall),
    .ex_mem_stall(s_ex_mem_stall), .mem_wb_stall(s_mem_wb_stall), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; id_uses_rt = 1'b0; ex_regwrite = 1'b0; ex_dREN = 1'b0;
    mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_redirect = 1'b0; wb_halt = 1'b0;
    id_rs = '0; id_rt = '0; ex_wsel = '0;
  endtask

  // Check the combinational decode, clock once, then check the counters.
  task automatic cyc(input string tag, input logic [9:0] exp, input int finc);
    #1;
    check({tag, ".outs"}, 32'(outs), 32'(exp));
    if (!exp[9] && !exp[0]) es++;
    ef += finc;
    @(posedge CLK);
    #1;
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(es));
    check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(ef));
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst.outs", 32'(outs), 32'(ADV));
    check("rst.state", 32'(dut.state), 32'(RUN));
    check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst.flush_cnt", 32'(flush_cnt), 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    ex_dREN = 1; ex_regwrite = 1; ex_wsel = 5; id_rs = 5;
    cyc("lu_rs", LU, 0);
    idle();
    cyc("lu_clear", ADV, 0);
    ex_dREN = 1; ex_regwrite = 1; ex_wsel = 0; id_rs = 0;
    cyc("lu_r0", ADV, 0);
    ex_wsel = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1;
    cyc("lu_rt", LU, 0);
    id_uses_rt = 0;
    cyc("lu_rt_unused", ADV, 0);
    idle();

    mem_dREN = 1;
    for (int i = 0; i < 3; i++) begin
      cyc("dmiss", MISS, 0);
      check("dmiss.state", 32'(dut.state), 32'(MEMWAIT));
    end
    dhit = 1;
    cyc("dhit", ADV, 0);
    check("dhit.state", 32'(dut.state), 32'(RUN));
    idle();

    ex_redirect = 1;
    cyc("redir_hit", RD_HIT, 1);
    ihit = 0;
    cyc("redir_nohit", RD_MISS, 1);
    check("pend_set", 32'(dut.redirect_pend), 32'd1);
    ex_redirect = 0;
    cyc("pend_wait", NOFETCH, 0);
    ihit = 1;
    cyc("pend_discard", DISCARD, 0);
    check("pend_clr", 32'(dut.redirect_pend), 32'd0);
    cyc("pend_after", ADV, 0);

    mem_dWEN = 1; ex_redirect = 1;
    cyc("miss_redir", MISS, 0);
    dhit = 1;
    cyc("miss_redir_dhit", RD_HIT, 1);
    idle();

    ex_redirect = 1; ihit = 0;
    cyc("redir2_nohit", RD_MISS, 1);
    ihit = 1;
    cyc("redir2_inpend", RD_HIT, 1);
    check("pend_kept", 32'(dut.redirect_pend), 32'd1);
    ex_redirect = 0;
    cyc("redir2_discard", DISCARD, 0);
    check("pend_clr2", 32'(dut.redirect_pend), 32'd0);

    wb_halt = 1;
    cyc("halt_enter", HALTING, 0);
    wb_halt = 0; ex_redirect = 1; mem_dREN = 1;
    for (int i = 0; i < 3; i++) cyc("halted", HALTED, 0);
    check("sat.stall_cnt", 32'(s_stall_cnt), 32'((es > 7) ? 7 : es));
    check("sat.flush_cnt", 32'(s_flush_cnt), 32'((ef > 7) ? 7 : ef));

    nRST = 0;
    #1;
    check("arst.halted", 32'(halted), 32'd0);
    check("arst.stall_cnt", 32'(stall_cnt), 32'd0);
    check("arst.flush_cnt", 32'(flush_cnt), 32'd0);
    nRST = 1;
    es = 0; ef = 0;
    idle();
    @(posedge CLK);
    #1;

    ex_redirect = 1; ihit = 0;
    cyc("pre_rst_redir", RD_MISS, 1);
    ex_redirect = 0; ihit = 1; mem_dREN = 1;
    cyc("pre_rst_miss", MISS, 0);
    check("pre_rst.state", 32'(dut.state), 32'(MEMWAIT));
    nRST = 0;
    #1;
    check("mid_rst.state", 32'(dut.state), 32'(RUN));
    check("mid_rst.pend", 32'(dut.redirect_pend), 32'd0);
    check("mid_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    nRST = 1;
    es = 0; ef = 0;
    idle();
    cyc("post_rst", ADV, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
